dequant_scheduler: RTL and testbench
====================================

DEQUANT_SCHEDULER -- requirements
Module: dequant_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 64, meaning the number of per-channel scale entries.
REQ-002 SHALL have parameter MULT_LAT, default 9, meaning total datapath latency: 1 input-register cycle plus 8 multiplier stages.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16 (power of two, >= MULT_LAT), meaning output buffer entries.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins a job when in IDLE.
REQ-007 num_elems  input  32  element count of the job, sampled on start.
REQ-008 cfg_we / cfg_addr / cfg_wdata  input  1 / $clog2(NUM_CH) / 32  scale-table write port.
REQ-009 in_valid / in_ready  input / output  1 / 1  input handshake.
REQ-010 in_data / in_ch  input  32 signed / $clog2(NUM_CH)  accumulator value and its channel index.
REQ-011 out_valid / out_ready  output / input  1 / 1  output handshake.
REQ-012 out_data  output  32 signed  dequantized result (product bits [47:16]).
REQ-013 busy / done  output  1 / 1  job active; one-cycle pulse at job end.

Function
REQ-014 SHALL implement FSM IDLE -> RUN on start with num_elems != 0; RUN -> DRAIN when the accepted count reaches num_elems; DRAIN -> IDLE when the emitted count reaches num_elems; done pulses on the DRAIN -> IDLE cycle.
REQ-015 SHALL treat start with num_elems == 0 as staying in IDLE and pulsing done the next cycle.
REQ-016 SHALL ignore start outside IDLE.
REQ-017 SHALL hold in_ready = (state == RUN) && (inflight + fifo_count < FIFO_DEPTH) && (accepted < num_elems).
REQ-018 SHALL, on each in_valid && in_ready cycle, present in_data and scale_tbl[in_ch] to the dequantize datapath with en = 1.
REQ-019 SHALL keep the datapath input at 0/0 on non-accept cycles.
REQ-020 SHALL track a MULT_LAT-deep valid shift register alongside the datapath.
REQ-021 SHALL push the datapath output into the FIFO exactly MULT_LAT cycles after acceptance.
REQ-022 SHALL ensure by credit (REQ-017) that a FIFO push never finds the FIFO full; no datapath stall exists.
REQ-023 SHALL drive out_valid = FIFO not empty and pop on out_valid && out_ready.
REQ-024 SHALL guarantee results leave in acceptance order.
REQ-025 SHALL, on a simultaneous FIFO push and pop, keep the count unchanged; with FIFO empty, the pushed word appears at the output the following cycle.
REQ-026 SHALL complete a scale-table write in one cycle; a write to an entry read in the same cycle returns the old value.
REQ-027 SHALL accept table writes in any state.
REQ-028 SHALL hold busy = (state != IDLE).

Reset
REQ-029 SHALL on rst force: state IDLE, counters 0, valid pipe 0, FIFO empty, out_valid 0, out_data 0, in_ready 0, busy 0, done 0.
REQ-030 SHALL on rst discard any in-flight work mid-job with no output.
REQ-031 SHALL leave scale-table contents unreset.

Configuration
REQ-032 SHALL, when DEQ_SCHED_PERF_EN is defined, add outputs perf_stall_cycles (32) and perf_bp_cycles (32).
REQ-033 perf_stall_cycles SHALL count cycles with in_valid && !in_ready in RUN.
REQ-034 perf_bp_cycles SHALL count cycles with out_valid && !out_ready.
REQ-035 SHALL clear both perf counters on rst and on start.
REQ-036 SHALL, without DEQ_SCHED_PERF_EN, omit the ports and the logic entirely.

Structure
REQ-037 SHALL place MULT_LAT, the default NUM_CH, and the FSM state enum in shared package dequant_pkg.
REQ-038 SHALL instantiate the existing dequantize block unchanged.
REQ-039 SHALL implement the output buffer as sub-module deq_sync_fifo.

Verification
REQ-040 Scale[3] = 0x0001_0000, start num_elems = 4, inputs 5,-7,100,0 on ch3 back-to-back, out_ready = 1 -> outputs 5,-7,100,0 in order; first output 10 cycles after first accept; done once.
REQ-041 Scale[0] = 0x0000_8000 (0.5), input 6 -> output 3; scale[1] = 0xFFFF_0000 (-1), input 9 -> output -9.
REQ-042 out_ready = 0, 40 inputs offered -> in_ready drops after exactly 16 accepts, no loss; release out_ready -> all 40 emerge in order, done pulses.
REQ-043 rst asserted 4 cycles into a 10-element job -> out_valid 0 next cycle, FSM IDLE, no stale output after a new start.
REQ-044 start with num_elems = 0 -> done pulses one cycle later, in_ready never asserted; start during RUN is ignored.
REQ-045 DEQ_SCHED_PERF_EN defined, out_ready = 0 for 7 cycles with data pending -> perf_bp_cycles = 7.

Source files
------------

// File: rtl/dequant_pkg.sv
// Shared definitions for the dequantization scheduler.
// Holds the datapath latency, the default scale-table size and the job FSM state type.
package dequant_pkg;

   localparam int unsigned MULT_LAT       = 9;   // 1 input register + 8 multiplier stages
   localparam int unsigned NUM_CH_DEFAULT = 64;
   localparam int unsigned DATA_W         = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/deq_sync_fifo.sv
// Synchronous output buffer for dequantized results.
// Ports: clk, rst (sync, active-high); push/wdata write; pop read;
// rdata is the head word (0 when empty); empty flag; count of stored words.
module deq_sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   // Pointer/count update; a push into a full buffer is only taken alongside a pop.
   always_comb begin
      do_pop  = pop && (count_q != '0);
      do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
      wr_d    = do_push ? wr_q + AW'(1) : wr_q;
      rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata;
   end

   assign empty = (count_q == '0);
   assign rdata = empty ? '0 : mem_q[rd_q];
   assign count = count_q;

endmodule

// File: rtl/dequantize.sv
// Pipelined dequantize datapath: p = (a * b)[47:16], LAT cycles from a/b to p.
// Ports: clk; en (load a/b this cycle, else zeros are loaded); a, b signed
// operands; p signed result.
module dequantize
   import dequant_pkg::*;
#(
   parameter int unsigned LAT = MULT_LAT
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [DATA_W-1:0] p
);

   localparam int unsigned STAGES = LAT - 1;

   logic signed [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic signed [DATA_W-1:0] p_q [STAGES];
   logic signed [DATA_W-1:0] p_d [STAGES];

   // First stage forms the Q16.16 product; the rest only delay it.
   always_comb begin
      a_d    = en ? a : '0;
      b_d    = en ? b : '0;
      p_d[0] = DATA_W'((64'(a_q) * 64'(b_q)) >>> 16);
      for (int i = 1; i < STAGES; i++) p_d[i] = p_q[i-1];
   end

   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
      for (int i = 0; i < STAGES; i++) p_q[i] <= p_d[i];
   end

   assign p = p_q[STAGES-1];

endmodule

// File: rtl/dequant_scheduler.sv
// Dequantization job scheduler: accepts num_elems accumulator values, multiplies
// each by its per-channel Q16.16 scale, and emits results in acceptance order.
// Ports: clk, rst (sync, active-high); start/num_elems job launch;
// cfg_we/cfg_addr/cfg_wdata scale-table write; in_valid/in_ready/in_data/in_ch
// input stream; out_valid/out_ready/out_data output stream; busy, done status.
// Optional: define DEQ_SCHED_PERF_EN to add perf_stall_cycles / perf_bp_cycles.
module dequant_scheduler #(
   parameter int unsigned NUM_CH     = dequant_pkg::NUM_CH_DEFAULT,
   parameter int unsigned MULT_LAT   = dequant_pkg::MULT_LAT,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [31:0]               num_elems,
   input  logic                      cfg_we,
   input  logic [$clog2(NUM_CH)-1:0] cfg_addr,
   input  logic [31:0]               cfg_wdata,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [31:0]        in_data,
   input  logic [$clog2(NUM_CH)-1:0] in_ch,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [31:0]        out_data,
   output logic                      busy,
   output logic                      done
`ifdef DEQ_SCHED_PERF_EN
  ,output logic [31:0]               perf_stall_cycles
  ,output logic [31:0]               perf_bp_cycles
`endif
);

   import dequant_pkg::*;

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned SUM_W = CNT_W + 1;

   state_t                 state_q, state_d;
   logic [31:0]            num_q, num_d, acc_q, acc_d, emit_q, emit_d;
   logic [CNT_W-1:0]       inflight_q, inflight_d;
   logic [MULT_LAT-1:0]    vpipe_q, vpipe_d;
   logic                   done_q, done_d;
   logic signed [31:0]     scale_tbl [NUM_CH];
   logic                   accept, push, pop, fifo_empty;
   logic [CNT_W-1:0]       fifo_count;
   logic [SUM_W-1:0]       credit_used;
   logic signed [31:0]     dp_a, dp_b, dp_p;

   // Scale table: unreset, writable in any state, read-before-write.
   always_ff @(posedge clk) begin
      if (cfg_we) scale_tbl[cfg_addr] <= cfg_wdata;
   end

   // Credit: every accepted word owns a FIFO slot from acceptance until popped.
   always_comb begin
      credit_used = SUM_W'(inflight_q) + SUM_W'(fifo_count);
      in_ready    = (state_q == ST_RUN) && (credit_used < SUM_W'(FIFO_DEPTH)) && (acc_q < num_q);
      accept      = in_valid && in_ready;
      dp_a        = accept ? in_data : '0;
      dp_b        = accept ? scale_tbl[in_ch] : '0;
      push        = vpipe_q[MULT_LAT-1];
      out_valid   = !fifo_empty;
      pop         = out_valid && out_ready;
   end

   // Job FSM and counters.
   always_comb begin
      state_d    = state_q;
      num_d      = num_q;
      acc_d      = accept ? acc_q + 32'd1 : acc_q;
      emit_d     = pop ? emit_q + 32'd1 : emit_q;
      done_d     = 1'b0;
      vpipe_d    = {vpipe_q[MULT_LAT-2:0], accept};
      inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(push);
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (num_elems == 32'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  num_d   = num_elems;
                  acc_d   = '0;
                  emit_d  = '0;
               end
            end
         end
         ST_RUN: begin
            if (acc_d == num_q) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (emit_d == num_q) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         num_q      <= '0;
         acc_q      <= '0;
         emit_q     <= '0;
         inflight_q <= '0;
         vpipe_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         num_q      <= num_d;
         acc_q      <= acc_d;
         emit_q     <= emit_d;
         inflight_q <= inflight_d;
         vpipe_q    <= vpipe_d;
         done_q     <= done_d;
      end
   end

   dequantize #(.LAT(MULT_LAT)) u_dequantize (
      .clk (clk),
      .en  (accept),
      .a   (dp_a),
      .b   (dp_b),
      .p   (dp_p)
   );

   deq_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (dp_p),
      .pop   (pop),
      .rdata (out_data),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;

`ifdef DEQ_SCHED_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d, perf_bp_q, perf_bp_d;

   // Stall and backpressure counters, cleared when a job is launched.
   always_comb begin
      perf_stall_d = perf_stall_q;
      perf_bp_d    = perf_bp_q;
      if (start && (state_q == ST_IDLE)) begin
         perf_stall_d = '0;
         perf_bp_d    = '0;
      end else begin
         if ((state_q == ST_RUN) && in_valid && !in_ready) perf_stall_d = perf_stall_q + 32'd1;
         if (out_valid && !out_ready) perf_bp_d = perf_bp_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_q <= '0;
         perf_bp_q    <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_bp_q    <= perf_bp_d;
      end
   end

   assign perf_stall_cycles = perf_stall_q;
   assign perf_bp_cycles    = perf_bp_q;
`endif

endmodule

// File: tb/tb_dequant_scheduler.sv
// Self-checking bench for dequant_scheduler. A transaction-level model tracks
// accepted words with their acceptance cycle; it predicts out_valid/out_data,
// in_ready, busy and done every cycle. Directed jobs pin the model with literals.
module tb_dequant_scheduler;

   localparam int unsigned NUM_CH     = 64;
   localparam int unsigned MULT_LAT   = 9;
   localparam int unsigned FIFO_DEPTH = 16;
   localparam int unsigned CH_W       = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst, start, cfg_we, in_valid, in_ready;
   logic                out_valid, out_ready, busy, done;
   logic [31:0]         num_elems, cfg_wdata;
   logic [CH_W-1:0]     cfg_addr, in_ch;
   logic signed [31:0]  in_data, out_data;
`ifdef DEQ_SCHED_PERF_EN
   logic [31:0]         perf_stall_cycles, perf_bp_cycles;
`endif

   dequant_scheduler #(.NUM_CH(NUM_CH), .MULT_LAT(MULT_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .num_elems(num_elems),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done)
`ifdef DEQ_SCHED_PERF_EN
     ,.perf_stall_cycles(perf_stall_cycles), .perf_bp_cycles(perf_bp_cycles)
`endif
   );

   typedef struct { int t; int v; } item_t;

   int    tests = 0;
   int    fails = 0;
   item_t items[$];            // accepted, not yet popped, oldest first
   int    scale_m [NUM_CH];
   bit    m_active, m_done, m_in_ready, m_out_valid;
   int    m_num, m_acc, m_emit, m_out_data;
   int    cyc = 0;
   bit    last_acc;
   int    popped[$];
   int    n_done, first_acc_cyc, first_val_cyc;
   int    fixed_d[$];
   int    fixed_ch;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected outputs for the current cycle.
   function automatic void model_outputs();
      m_out_valid = (items.size() > 0) && (items[0].t + int'(MULT_LAT) + 1 <= cyc);
      m_out_data  = m_out_valid ? items[0].v : 0;
      m_in_ready  = m_active && (m_acc < m_num) && (items.size() < int'(FIFO_DEPTH));
   endfunction

   task automatic compare_outputs();
      model_outputs();
      check("out_valid", longint'(out_valid), longint'(m_out_valid));
      if (m_out_valid) check("out_data", longint'(out_data), longint'(m_out_data));
      check("in_ready", longint'(in_ready), longint'(m_in_ready));
      check("busy", longint'(busy), longint'(m_active));
      check("done", longint'(done), longint'(m_done));
      if (done) n_done++;
      if (out_valid && first_val_cyc < 0) first_val_cyc = cyc;
   endtask

   // Advance the model across the coming clock edge using the driven inputs.
   task automatic model_step();
      bit        old_active;
      logic [63:0] prod;
      old_active = m_active;
      last_acc   = 1'b0;
      if (out_valid && out_ready) popped.push_back(int'(out_data));
      if (rst) begin
         items.delete();
         m_active = 1'b0; m_done = 1'b0;
         m_num = 0; m_acc = 0; m_emit = 0;
      end else begin
         m_done = 1'b0;
         if (in_valid && m_in_ready) begin
            prod = 64'(longint'(in_data) * longint'(scale_m[in_ch]));
            items.push_back('{cyc, int'(prod[47:16])});
            m_acc++;
            last_acc = 1'b1;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
         end
         if (m_out_valid && out_ready) begin
            void'(items.pop_front());
            m_emit++;
            if (m_active && m_emit == m_num) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end
         end
         if (start && !old_active) begin
            if (num_elems == 32'd0) m_done = 1'b1;
            else begin
               m_active = 1'b1; m_num = int'(num_elems); m_acc = 0; m_emit = 0;
            end
         end
      end
      if (cfg_we) scale_m[cfg_addr] = int'(cfg_wdata);
      cyc++;
   endtask

   task automatic tick();
      model_step();
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic idle_inputs();
      start = 0; num_elems = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
      in_valid = 0; in_data = 0; in_ch = 0; out_ready = 0;
   endtask

   task automatic clear_log();
      popped.delete(); n_done = 0; first_acc_cyc = -1; first_val_cyc = -1;
   endtask

   // One job: pv/pr are in_valid/out_ready percentages; out_ready held low for
   // the first 'hold' cycles; poke issues an extra start mid-job.
   task automatic run_job(input int n, input int pv, input int pr, input int hold,
                          input bit poke, input bit use_fixed, output int acc_at_hold);
      int sent = 0;
      int k = 0;
      int budget = 3000;
      acc_at_hold = 0;
      clear_log();
      start = 1; num_elems = 32'(n); tick(); start = 0;
      while (n_done == 0 && budget > 0) begin
         in_valid  = (sent < n) && ($urandom_range(99) < 32'(pv));
         in_data   = (use_fixed && sent < fixed_d.size()) ? fixed_d[sent] : $urandom;
         in_ch     = use_fixed ? CH_W'(fixed_ch) : CH_W'($urandom_range(7));
         out_ready = (k >= hold) && ($urandom_range(99) < 32'(pr));
         cfg_we    = !use_fixed && ($urandom_range(99) < 10);
         cfg_addr  = CH_W'($urandom_range(7));
         cfg_wdata = $urandom;
         start     = poke && (k == 3);
         num_elems = 32'd99;
         if (k == hold) acc_at_hold = sent;
         tick();
         if (last_acc) sent++;
         k++;
         budget--;
      end
      check("job_done_within_budget", longint'(n_done), 1);
      idle_inputs();
      repeat (3) tick();
   endtask

   int acc_h;
   int jn;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      clear_log();
      rst = 1;
      repeat (3) tick();
      rst = 0;
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_out_data", longint'(out_data), 0);
      check("rst_in_ready", longint'(in_ready), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);

      // Load the whole scale table.
      for (int i = 0; i < int'(NUM_CH); i++) begin
         cfg_we = 1; cfg_addr = CH_W'(i);
         cfg_wdata = (i == 3) ? 32'h0001_0000 : (i == 0) ? 32'h0000_8000 :
                     (i == 1) ? 32'hFFFF_0000 : $urandom;
         tick();
      end
      idle_inputs();
      tick();

      // Unity scale, back-to-back stream.
      fixed_d = '{5, -7, 100, 0}; fixed_ch = 3;
      run_job(4, 100, 100, 0, 0, 1, acc_h);
      check("unity_count", longint'(popped.size()), 4);
      if (popped.size() == 4) begin
         check("unity_out0", longint'(popped[0]), 5);
         check("unity_out1", longint'(popped[1]), -7);
         check("unity_out2", longint'(popped[2]), 100);
         check("unity_out3", longint'(popped[3]), 0);
      end
      check("first_out_latency", longint'(first_val_cyc - first_acc_cyc), 10);
      check("unity_done_once", longint'(n_done), 1);

      // Fractional and negative scales.
      fixed_d = '{6}; fixed_ch = 0;
      run_job(1, 100, 100, 0, 0, 1, acc_h);
      check("half_scale", longint'(popped.size() > 0 ? popped[0] : 12345), 3);
      fixed_d = '{9}; fixed_ch = 1;
      run_job(1, 100, 100, 0, 0, 1, acc_h);
      check("neg_scale", longint'(popped.size() > 0 ? popped[0] : 12345), -9);

      // Zero-length job.
      clear_log();
      start = 1; num_elems = 0; tick(); start = 0;
      check("zero_job_done", longint'(done), 1);
      check("zero_job_busy", longint'(busy), 0);
      repeat (3) tick();
      check("zero_job_done_once", longint'(n_done), 1);

      // Start during RUN is ignored.
      run_job(5, 100, 100, 0, 1, 0, acc_h);
      check("start_in_run_ignored", longint'(popped.size()), 5);

      // Credit limit under full backpressure.
      run_job(40, 100, 100, 40, 0, 0, acc_h);
      check("credit_accepts", longint'(acc_h), 16);
      check("credit_all_out", longint'(popped.size()), 40);

      // Reset mid-job.
      start = 1; num_elems = 10; tick(); start = 0;
      in_valid = 1; out_ready = 1; in_ch = 3;
      repeat (3) begin in_data = $urandom; tick(); end
      idle_inputs();
      rst = 1; tick(); rst = 0;
      check("midrst_out_valid", longint'(out_valid), 0);
      check("midrst_busy", longint'(busy), 0);
      check("midrst_in_ready", longint'(in_ready), 0);
      repeat (12) tick();
      run_job(3, 100, 100, 0, 0, 0, acc_h);
      check("post_rst_count", longint'(popped.size()), 3);

      // Randomized jobs.
      for (int j = 0; j < 8; j++) begin
         jn = int'($urandom_range(40, 1));
         run_job(jn, int'($urandom_range(100, 20)), int'($urandom_range(100, 20)), 0, 0, 0, acc_h);
         check("rand_job_count", longint'(popped.size()), longint'(jn));
      end

`ifdef DEQ_SCHED_PERF_EN
      // Backpressure counter.
      begin
         int b;
         clear_log();
         start = 1; num_elems = 1; tick(); start = 0;
         in_valid = 1; in_data = 1; in_ch = 3; out_ready = 0;
         b = 20;
         while (!last_acc && b > 0) begin tick(); b--; end
         in_valid = 0;
         b = 30;
         while (!m_out_valid && b > 0) begin tick(); b--; end
         check("perf_wait_valid", longint'(m_out_valid), 1);
         repeat (7) tick();
         check("perf_bp_cycles", longint'(perf_bp_cycles), 7);
         check("perf_stall_cycles", longint'(perf_stall_cycles), 0);
         out_ready = 1;
         b = 20;
         while (n_done == 0 && b > 0) begin tick(); b--; end
         check("perf_job_done", longint'(n_done), 1);
         idle_inputs();
         tick();
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
